// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
//   Shared types and helpers for the parametrised LIFO stack.
//   - cmd_e   : two-bit command encoding driven by the command sequencer.
//   - mod_sub : (a - b) mod depth without negative intermediates, used by the
//               pointer decrement and by the GET address calculation.
// -----------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

    // Adds depth before subtracting so the intermediate never goes negative.
    // Valid for a < depth and b <= depth; callers truncate to pointer width.
    function automatic int unsigned mod_sub(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned depth);
        int unsigned t;
        t = a + depth - b;
        if (t >= depth) begin
            t = t - depth;
        end
        return t;
    endfunction

endpackage

// File: rtl/stack_ptr_mod.sv
// -----------------------------------------------------------------------------
// stack_ptr_mod
//   Modulo-DEPTH up/down pointer register. Wraps DEPTH-1 -> 0 on INC and
//   0 -> DEPTH-1 on DEC; INC and DEC together hold.
// Ports
//   CLK   in  1      rising-edge clock
//   RESET in  1      synchronous active-high reset, pointer -> 0
//   INC   in  1      advance pointer
//   DEC   in  1      retreat pointer
//   PTR   out IDX_W  current pointer value
// -----------------------------------------------------------------------------
module stack_ptr_mod
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             INC,
    input  logic             DEC,
    output logic [IDX_W-1:0] PTR
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PTR <= '0;
        end else if (INC && !DEC) begin
            PTR <= (PTR == IDX_W'(DEPTH - 1)) ? '0 : PTR + 1'b1;
        end else if (DEC && !INC) begin
            PTR <= IDX_W'(mod_sub(32'(PTR), 32'd1, DEPTH));
        end
    end

endmodule

// File: rtl/stack_param_lifo.sv
// -----------------------------------------------------------------------------
// stack_param_lifo
//   Parametrised LIFO stack with PUSH / POP / indexed GET over a circular
//   register store of DEPTH words (any DEPTH >= 2). Registered result with a
//   one-cycle valid pulse, one-cycle error pulse for rejected commands, and
//   occupancy / FULL / EMPTY status.
//   Build option: define STACK_WRAP_EN to let PUSH on a full stack overwrite
//   the oldest entry; otherwise such a PUSH is rejected with ERR.
// Ports
//   CLK      in  1       rising-edge clock
//   RESET    in  1       synchronous active-high reset (beats any COMMAND)
//   COMMAND  in  2       00 NOP, 01 PUSH, 10 POP, 11 GET
//   INDEX    in  IDX_W   GET depth from top, 0 = top of stack
//   I_DATA   in  DATA_W  PUSH data
//   O_DATA   out DATA_W  POP/GET result (registered, holds otherwise)
//   O_VALID  out 1       O_DATA updated this cycle
//   ERR      out 1       previous command was rejected
//   FULL     out 1       COUNT == DEPTH
//   EMPTY    out 1       COUNT == 0
//   COUNT    out CNT_W   current occupancy
// -----------------------------------------------------------------------------
module stack_param_lifo
    import stack_pkg::*;
#(
    parameter  int unsigned DATA_W = 4,
    parameter  int unsigned DEPTH  = 5,
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        COMMAND,
    input  logic [IDX_W-1:0]  INDEX,
    input  logic [DATA_W-1:0] I_DATA,
    output logic [DATA_W-1:0] O_DATA,
    output logic              O_VALID,
    output logic              ERR,
    output logic              FULL,
    output logic              EMPTY,
    output logic [CNT_W-1:0]  COUNT
);

    cmd_e              cmd;
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  top_ptr;
    logic [IDX_W-1:0]  get_addr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              is_full;
    logic              is_empty;
    logic              push_ok;
    logic              pop_ok;
    logic              get_ok;
    logic              reject;

    assign cmd      = cmd_e'(COMMAND);
    assign is_full  = (count == CNT_W'(DEPTH));
    assign is_empty = (count == '0);
    assign FULL     = is_full;
    assign EMPTY    = is_empty;
    assign COUNT    = count;

    stack_ptr_mod #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_wr_ptr (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (push_ok),
        .DEC   (pop_ok),
        .PTR   (wr_ptr)
    );

    always_comb begin
        push_ok  = 1'b0;
        pop_ok   = 1'b0;
        get_ok   = 1'b0;
        reject   = 1'b0;
        top_ptr  = IDX_W'(mod_sub(32'(wr_ptr), 32'd1, DEPTH));
        // Only meaningful when INDEX < count; out-of-range INDEX is never used.
        get_addr = IDX_W'(mod_sub(32'(top_ptr), 32'(INDEX), DEPTH));
        case (cmd)
            CMD_PUSH: begin
`ifdef STACK_WRAP_EN
                push_ok = 1'b1;
`else
                push_ok = !is_full;
                reject  = is_full;
`endif
            end
            CMD_POP: begin
                pop_ok = !is_empty;
                reject = is_empty;
            end
            CMD_GET: begin
                get_ok = (CNT_W'(INDEX) < count);
                reject = !get_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            count   <= '0;
            O_DATA  <= '0;
            O_VALID <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            O_VALID <= pop_ok || get_ok;
            ERR     <= reject;
            if (push_ok) begin
                mem[wr_ptr] <= I_DATA;
            end
            if (pop_ok) begin
                O_DATA <= mem[top_ptr];
            end else if (get_ok) begin
                O_DATA <= mem[get_addr];
            end
            // A wrapping PUSH on a full stack overwrites the oldest slot and
            // leaves the occupancy at DEPTH.
            if (push_ok && !is_full) begin
                count <= count + 1'b1;
            end else if (pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_param_lifo.sv
module tb_stack_param_lifo;
    import stack_pkg::*;

    localparam int unsigned DW = 4;
    localparam int unsigned DP = 5;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] COMMAND = CMD_NOP;
    logic [2:0] INDEX = '0;
    logic [3:0] I_DATA = '0;
    logic [3:0] O_DATA;
    logic       O_VALID;
    logic       ERR;
    logic       FULL;
    logic       EMPTY;
    logic [2:0] COUNT;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic       e;
        logic [3:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] last_d = '0;

    stack_param_lifo #(
        .DATA_W (DW),
        .DEPTH  (DP)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .COMMAND (COMMAND),
        .INDEX   (INDEX),
        .I_DATA  (I_DATA),
        .O_DATA  (O_DATA),
        .O_VALID (O_VALID),
        .ERR     (ERR),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .COUNT   (COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command per cycle: drive on the falling edge, record the expected
    // response, then compare just after the next rising edge.
    task automatic step(input logic rst, input cmd_e c, input logic [2:0] idx,
                        input logic [3:0] din, input logic ev, input logic ee,
                        input logic [3:0] ed, input string tag);
        exp_t e;
        @(negedge CLK);
        RESET   = rst;
        COMMAND = c;
        INDEX   = idx;
        I_DATA  = din;
        sb.push_back('{v: ev, e: ee, d: ed});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({tag, "_valid"}, 32'(O_VALID), 32'(e.v));
        chk({tag, "_err"},   32'(ERR),     32'(e.e));
        chk({tag, "_data"},  32'(O_DATA),  32'(e.d));
        RESET   = 1'b0;
        COMMAND = CMD_NOP;
    endtask

    task automatic chk_state(input string tag, input int cnt);
        chk({tag, "_count"}, 32'(COUNT), 32'(cnt));
        chk({tag, "_full"},  32'(FULL),  32'(cnt == int'(DP)));
        chk({tag, "_empty"}, 32'(EMPTY), 32'(cnt == 0));
    endtask

    task automatic do_reset();
        last_d = '0;
        step(1'b1, CMD_NOP, 3'd0, 4'd0, 1'b0, 1'b0, 4'd0, "reset");
    endtask

    task automatic do_push(input logic [3:0] d);
        step(1'b0, CMD_PUSH, 3'd0, d, 1'b0, 1'b0, last_d, "push");
    endtask

    task automatic do_pop(input logic [3:0] d);
        last_d = d;
        step(1'b0, CMD_POP, 3'd0, 4'd0, 1'b1, 1'b0, d, "pop");
    endtask

    task automatic do_pop_err();
        step(1'b0, CMD_POP, 3'd0, 4'd0, 1'b0, 1'b1, last_d, "pop_empty");
    endtask

    task automatic do_get(input logic [2:0] i, input logic [3:0] d);
        last_d = d;
        step(1'b0, CMD_GET, i, 4'd0, 1'b1, 1'b0, d, "get");
    endtask

    task automatic do_get_err(input logic [2:0] i);
        step(1'b0, CMD_GET, i, 4'd0, 1'b0, 1'b1, last_d, "get_range");
    endtask

    initial begin
        do_reset();
        do_reset();
        chk_state("rst", 0);

        // 1: POP on empty
        do_pop_err();
        chk_state("t1", 0);

        // 2: GET within and beyond occupancy
        do_push(4'd3);
        do_push(4'd7);
        do_push(4'd9);
        chk_state("t2a", 3);
        do_get(3'd0, 4'd9);
        do_get(3'd2, 4'd3);
        do_get_err(3'd3);
        do_get_err(3'd7);
        chk_state("t2b", 3);
        do_pop(4'd9);
        do_pop(4'd7);
        do_pop(4'd3);
        chk_state("t2c", 0);

        // 3: fill, then PUSH on full
        for (int i = 1; i <= 5; i++) do_push(4'(i));
        chk_state("t3a", 5);
`ifdef STACK_WRAP_EN
        step(1'b0, CMD_PUSH, 3'd0, 4'd6, 1'b0, 1'b0, last_d, "push_full_wrap");
        chk_state("t3b", 5);
        for (int i = 6; i >= 2; i--) do_pop(4'(i));
`else
        step(1'b0, CMD_PUSH, 3'd0, 4'd6, 1'b0, 1'b1, last_d, "push_full_rej");
        chk_state("t3b", 5);
        for (int i = 5; i >= 1; i--) do_pop(4'(i));
`endif
        chk_state("t3c", 0);
        do_pop_err();

        // 4: pointer wrap from a fresh reset
        do_reset();
        for (int i = 1; i <= 4; i++) do_push(4'(i));
        do_pop(4'd4);
        do_pop(4'd3);
        do_pop(4'd2);
        do_push(4'hA);
        do_push(4'hB);
        do_push(4'hC);
        do_push(4'hD);
        chk_state("t4", 5);
        chk("t4_wr_ptr", 32'(dut.wr_ptr), 32'd0);
        do_get(3'd0, 4'hD);
        do_get(3'd1, 4'hC);
        do_get(3'd2, 4'hB);
        do_get(3'd3, 4'hA);
        do_get(3'd4, 4'h1);

        // 5: reset wins over a simultaneous PUSH
        last_d = '0;
        step(1'b1, CMD_PUSH, 3'd0, 4'd8, 1'b0, 1'b0, 4'd0, "rst_push");
        chk_state("t5", 0);
        do_get_err(3'd0);
        for (int i = 0; i < int'(DP); i++) begin
            chk("t5_mem", 32'(dut.mem[i]), 32'd0);
        end

        // 6: back-to-back PUSH/POP pairs
        do_push(4'd5);
        do_pop(4'd5);
        do_push(4'd2);
        do_pop(4'd2);
        chk_state("t6", 0);

        @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
